// File: rtl/matmul_compute.sv
// ---------------------------------------------------------------------------
// matmul_compute
//
// Compute stage of the matrix-multiplication accelerator. Reads A (dim0 x dim1,
// row-major) and B (dim1 x dim2, row-major) back from their buffers and builds
// C = A*B one element at a time through a single multiply-accumulate datapath.
// Each C element is written at row-major address i*dim2+j; a one-cycle done
// pulse follows the last write.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 begin a multiplication (sampled only in IDLE)
//   i_dim0/i_dim1/i_dim2    matrix dimensions, stable from start until done
//   o_aadrr, i_adata        A buffer read port (1-cycle read latency)
//   o_badrr, i_bdata        B buffer read port (1-cycle read latency)
//   o_cadrw, o_cdata,
//   o_cbufwrite             C buffer write port
//   o_busy                  high in every state except IDLE
//   o_done                  one-cycle completion pulse
//   o_state                 current FSM state, for observation
//
// Handshake: there is no valid/ready pair. i_start is a level sampled only in
// IDLE; o_cbufwrite qualifies o_cadrw/o_cdata for exactly one cycle per
// element; o_done marks the cycle after the final write (or the cycle after
// INIT when any dimension is zero).
// ---------------------------------------------------------------------------
module matmul_compute #(
    parameter int n = 8,
    parameter int m = 16,
    parameter int w = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [n-1:0]   i_dim0,
    input  logic [n-1:0]   i_dim1,
    input  logic [n-1:0]   i_dim2,
    output logic [m-1:0]   o_aadrr,
    output logic [m-1:0]   o_badrr,
    input  logic [w-1:0]   i_adata,
    input  logic [w-1:0]   i_bdata,
    output logic [m-1:0]   o_cadrw,
    output logic [2*w-1:0] o_cdata,
    output logic           o_cbufwrite,
    output logic           o_busy,
    output logic           o_done,
    output logic [2:0]     o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_LAST  = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [n-1:0]   r_ci;
    logic [n-1:0]   r_cj;
    logic [n-1:0]   r_ck;
    logic [2*w-1:0] r_acc;
    logic [m-1:0]   r_base;     // i*dim1, advanced by dim1 on each new row

    logic           w_last_i;
    logic           w_last_j;
    logic           w_last_k;
    logic           w_zero_dim;
    logic [2*w-1:0] w_prod;
    logic [m-1:0]   w_ci_m;
    logic [m-1:0]   w_cj_m;
    logic [m-1:0]   w_ck_m;
    logic [m-1:0]   w_dim1_m;
    logic [m-1:0]   w_dim2_m;

    // The last-index compares are only consulted when every dimension is
    // nonzero, so the dim-1 subtraction cannot underflow where it matters.
    assign w_last_i   = (r_ci == i_dim0 - n'(1));
    assign w_last_j   = (r_cj == i_dim2 - n'(1));
    assign w_last_k   = (r_ck == i_dim1 - n'(1));
    assign w_zero_dim = (i_dim0 == '0) || (i_dim1 == '0) || (i_dim2 == '0);

    // Unsigned w x w -> 2w product of the data returned for the previous read.
    assign w_prod = {{w{1'b0}}, i_adata} * {{w{1'b0}}, i_bdata};

    // Address arithmetic is carried out in m bits and truncates naturally.
    assign w_ci_m   = m'(r_ci);
    assign w_cj_m   = m'(r_cj);
    assign w_ck_m   = m'(r_ck);
    assign w_dim1_m = m'(i_dim1);
    assign w_dim2_m = m'(i_dim2);

    assign o_aadrr = r_base + w_ck_m;
    assign o_badrr = w_ck_m * w_dim2_m + w_cj_m;
    assign o_cadrw = w_ci_m * w_dim2_m + w_cj_m;
    assign o_cdata = r_acc;
    assign o_state = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_cbufwrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                w_next = w_zero_dim ? S_FIN : S_READ;
            end
            S_READ: begin
                if (w_last_k) begin
                    w_next = S_LAST;
                end
            end
            S_LAST: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                o_cbufwrite = 1'b1;
                w_next      = (w_last_j && w_last_i) ? S_FIN : S_READ;
            end
            S_FIN: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ci   <= '0;
            r_cj   <= '0;
            r_ck   <= '0;
            r_acc  <= '0;
            r_base <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ci   <= '0;
                    r_cj   <= '0;
                    r_ck   <= '0;
                    r_acc  <= '0;
                    r_base <= '0;
                end
                S_READ: begin
                    // Read data lags the address by one cycle: at k=0 nothing
                    // valid has returned yet, so the accumulator restarts.
                    if (r_ck == '0) begin
                        r_acc <= '0;
                    end else begin
                        r_acc <= r_acc + w_prod;
                    end
                    if (!w_last_k) begin
                        r_ck <= r_ck + n'(1);
                    end
                end
                S_LAST: begin
                    r_acc <= r_acc + w_prod;
                end
                S_WRITE: begin
                    r_ck <= '0;
                    if (!w_last_j) begin
                        r_cj <= r_cj + n'(1);
                    end else if (!w_last_i) begin
                        r_cj   <= '0;
                        r_ci   <= r_ci + n'(1);
                        r_base <= r_base + w_dim1_m;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_compute.sv
module tb_matmul_compute;

  localparam int N = 8;
  localparam int M = 16;
  localparam int W = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [N-1:0]   dim0 = '0;
  logic [N-1:0]   dim1 = '0;
  logic [N-1:0]   dim2 = '0;
  logic [M-1:0]   aadrr;
  logic [M-1:0]   badrr;
  logic [W-1:0]   adata;
  logic [W-1:0]   bdata;
  logic [M-1:0]   cadrw;
  logic [2*W-1:0] cdata;
  logic           cbufwrite;
  logic           busy;
  logic           done;
  logic [2:0]     state;

  matmul_compute #(.n(N), .m(M), .w(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_dim0(dim0), .i_dim1(dim1), .i_dim2(dim2),
    .o_aadrr(aadrr), .o_badrr(badrr), .i_adata(adata), .i_bdata(bdata),
    .o_cadrw(cadrw), .o_cdata(cdata), .o_cbufwrite(cbufwrite),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  // ---------------- buffer models (1-cycle synchronous read) ----------------
  logic [W-1:0] amem [256];
  logic [W-1:0] bmem [256];
  always @(posedge clk) begin
    adata <= amem[aadrr[7:0]];
    bdata <= bmem[badrr[7:0]];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // {cadrw, cdata} per expected write
  logic [31:0] exp_a[$];   // expected aadrr per READ cycle
  logic [31:0] exp_b[$];   // expected badrr per READ cycle
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      amem[i] = '0;
      bmem[i] = '0;
    end
  endtask

  task automatic pulse_start(input int d0, input int d1, input int d2);
    dim0 = N'(d0);
    dim1 = N'(d1);
    dim2 = N'(d2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);   // edge 0
    #1 start = 1'b0;
  endtask

  task automatic check_write();
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check("cwr", {cadrw, cdata}, e);
  endtask

  // Runs one multiplication; cycle c is the interval after clock edge c-1.
  task automatic run_mm(input int d0, input int d1, input int d2,
                        input int exp_first_wr, input int exp_done);
    int first_wr;
    int done_cyc;
    first_wr = -1;
    done_cyc = -1;
    pulse_start(d0, d1, d2);
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      check("busy_run", {31'd0, busy}, 32'd1);
      if (cbufwrite) begin
        if (first_wr < 0) first_wr = c;
        check_write();
      end
      if (state == ST_READ && exp_a.size() > 0) begin
        check("aadrr", {16'd0, aadrr}, exp_a.pop_front());
        check("badrr", {16'd0, badrr}, exp_b.pop_front());
      end
      if (done) done_cyc = c;
    end
    if (exp_first_wr >= 0) check("first_wr_cyc", first_wr, exp_first_wr);
    check("done_cyc", done_cyc, exp_done);
    check("wr_left", exp_q.size(), 0);
    check("rd_left", exp_a.size(), 0);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
  endtask

  task automatic load_2x2x2();
    clear_mem();
    amem[0] = 8'd1; amem[1] = 8'd2; amem[2] = 8'd3; amem[3] = 8'd4;
    bmem[0] = 8'd5; bmem[1] = 8'd6; bmem[2] = 8'd7; bmem[3] = 8'd8;
  endtask

  task automatic expect_2x2x2();
    exp_q.push_back({16'd0, 16'd19});
    exp_q.push_back({16'd1, 16'd22});
    exp_q.push_back({16'd2, 16'd43});
    exp_q.push_back({16'd3, 16'd50});
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},  {31'd0, busy}, 32'd0);
    check({pfx, "_done"},  {31'd0, done}, 32'd0);
    check({pfx, "_cbw"},   {31'd0, cbufwrite}, 32'd0);
    check({pfx, "_aadrr"}, {16'd0, aadrr}, 32'd0);
    check({pfx, "_badrr"}, {16'd0, badrr}, 32'd0);
    check({pfx, "_cadrw"}, {16'd0, cadrw}, 32'd0);
    check({pfx, "_cdata"}, {16'd0, cdata}, 32'd0);
    check({pfx, "_state"}, {29'd0, state}, {29'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_mem();
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2x2x2: C = [19 22; 43 50], writes in cycles 5,9,13,17, done in 18
    load_2x2x2();
    expect_2x2x2();
    run_mm(2, 2, 2, 5, 18);

    // 1x1x1: 3*4 = 12
    clear_mem();
    amem[0] = 8'd3; bmem[0] = 8'd4;
    exp_q.push_back({16'd0, 16'd12});
    run_mm(1, 1, 1, 4, 5);

    // 2x3x1 non-square, with read address sequences
    clear_mem();
    for (int i = 0; i < 6; i++) amem[i] = W'(i + 1);
    for (int i = 0; i < 3; i++) bmem[i] = 8'd1;
    exp_q.push_back({16'd0, 16'd6});
    exp_q.push_back({16'd1, 16'd15});
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(i);
      exp_b.push_back(i % 3);
    end
    run_mm(2, 3, 1, 6, 12);

    // 1x2x1 wrap: 2*255*255 = 130050 -> 64514
    clear_mem();
    amem[0] = 8'hFF; amem[1] = 8'hFF; bmem[0] = 8'hFF; bmem[1] = 8'hFF;
    exp_q.push_back({16'd0, 16'd64514});
    run_mm(1, 2, 1, 5, 6);

    // dim1 = 0: no writes, done in cycle 2, busy cycles 1-2 only
    run_mm(3, 0, 2, -1, 2);

    // reset during READ of element 2; mid-run start ignored
    load_2x2x2();
    exp_q.push_back({16'd0, 16'd19});
    pulse_start(2, 2, 2);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (cbufwrite) check_write();
      if (c == 6) begin
        check("pre_rst_state", {29'd0, state}, {29'd0, ST_READ});
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
      end
    end
    check("midrst_wr_left", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_cbw", {31'd0, cbufwrite}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // fresh start after reset reproduces the full result
    expect_2x2x2();
    run_mm(2, 2, 2, 5, 18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
